// File: rtl/div_pkg.sv
// Shared types and constants for the Execute-stage multi-cycle divider.
// The result is packed as {remainder, quotient}.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  // Field offsets inside the 2*DIV_WIDTH result word.
  localparam int QUO_LSB = 0;
  localparam int REM_LSB = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Shifts the next dividend bit into the partial remainder, then trial-subtracts the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendMsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             quoBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the top bit of the difference is exactly the borrow.
  assign shifted = {remIn, dividendMsb};
  assign diff    = shifted - {1'b0, divisor};
  assign quoBit  = ~diff[WIDTH];
  assign remOut  = quoBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the Execute stage: one quotient bit per cycle,
// holding the pipeline through divstallE and presenting {rem, quo} for one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signedE,
  input  logic [WIDTH-1:0]   opaE,
  input  logic [WIDTH-1:0]   opbE,
  input  logic               cancelE,
  output logic               divstallE,
  output logic               div_readyE,
  output logic [2*WIDTH-1:0] div_resultE
);

  divState_t          stateReg;
  logic [CNT_W-1:0]   cntReg;
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   dividendReg;
  logic [WIDTH-1:0]   divisorReg;
  logic [WIDTH-1:0]   opaRawReg;
  logic               qSignReg;
  logic               rSignReg;
  logic               divZeroReg;
  logic               readyReg;
  logic [2*WIDTH-1:0] resultReg;

  logic [WIDTH-1:0]   opaAbs;
  logic [WIDTH-1:0]   opbAbs;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quoNext;
  logic [WIDTH-1:0]   quoFinal;
  logic [WIDTH-1:0]   remFinal;
  logic               quoBit;
  logic               lastIter;
  logic               accept;

  assign opaAbs = (signedE && opaE[WIDTH-1]) ? -opaE : opaE;
  assign opbAbs = (signedE && opbE[WIDTH-1]) ? -opbE : opbE;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .remIn      (remReg),
    .dividendMsb(dividendReg[WIDTH-1]),
    .divisor    (divisorReg),
    .remOut     (remNext),
    .quoBit     (quoBit)
  );

  // The dividend register doubles as the quotient: bits shift out the top
  // while quotient bits shift in at the bottom.
  assign quoNext  = {dividendReg[WIDTH-2:0], quoBit};
  assign lastIter = (cntReg == CNT_W'(WIDTH - 1));

  always_comb begin
    quoFinal = qSignReg ? -quoNext : quoNext;
    remFinal = rSignReg ? -remNext : remNext;
    if (divZeroReg) begin
      quoFinal = '1;
      remFinal = opaRawReg;
    end
  end

  // Stall must rise in the very cycle the DIV reaches E, hence combinational.
  assign accept    = (stateReg == DIV_IDLE) && startE && !cancelE;
  assign divstallE = accept || ((stateReg == DIV_BUSY) && !cancelE);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= DIV_IDLE;
      cntReg      <= '0;
      remReg      <= '0;
      dividendReg <= '0;
      divisorReg  <= '0;
      opaRawReg   <= '0;
      qSignReg    <= 1'b0;
      rSignReg    <= 1'b0;
      divZeroReg  <= 1'b0;
      readyReg    <= 1'b0;
      resultReg   <= '0;
    end else begin
      readyReg <= 1'b0;
      case (stateReg)
        DIV_IDLE: begin
          if (accept) begin
            remReg      <= '0;
            dividendReg <= opaAbs;
            divisorReg  <= opbAbs;
            opaRawReg   <= opaE;
            qSignReg    <= signedE && (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
            rSignReg    <= signedE && opaE[WIDTH-1];
            divZeroReg  <= (opbE == '0);
            cntReg      <= '0;
            stateReg    <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (cancelE) begin
            stateReg <= DIV_IDLE;
          end else begin
            remReg      <= remNext;
            dividendReg <= quoNext;
            cntReg      <= cntReg + CNT_W'(1);
            if (lastIter) begin
              stateReg  <= DIV_DONE;
              readyReg  <= 1'b1;
              resultReg <= {remFinal, quoFinal};
            end
          end
        end
        // A start seen here is still the same DIV instruction; never re-accept it.
        DIV_DONE: stateReg <= DIV_IDLE;
        default:  stateReg <= DIV_IDLE;
      endcase
    end
  end

  assign div_readyE  = readyReg;
  assign div_resultE = resultReg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stall window length, sign handling, divide-by-zero,
// overflow, cancel and reset behaviour against hand-computed results.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic           clk = 1'b0;
  logic           rst;
  logic           startE;
  logic           signedE;
  logic [W-1:0]   opaE;
  logic [W-1:0]   opbE;
  logic           cancelE;
  logic           divstallE;
  logic           div_readyE;
  logic [2*W-1:0] div_resultE;

  int testCnt = 0;
  int failCnt = 0;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(W),
    .CNT_W(DIV_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .opaE       (opaE),
    .opbE       (opbE),
    .cancelE    (cancelE),
    .divstallE  (divstallE),
    .div_readyE (div_readyE),
    .div_resultE(div_resultE)
  );

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one DIV at posedge+1 of an IDLE cycle, holds startE while stalled,
  // checks the stall window and the DONE-cycle result, then drops startE.
  task automatic runDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expQ, input logic [W-1:0] expR, input string tag);
    int stalls;
    bit seenDone;
    bit earlyReady;
    startE     = 1'b1;
    signedE    = sgn;
    opaE       = a;
    opbE       = b;
    stalls     = 0;
    seenDone   = 1'b0;
    earlyReady = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!divstallE) begin
        seenDone = 1'b1;
        break;
      end
      stalls++;
      if (div_readyE) earlyReady = 1'b1;
      nextCycle();
    end
    chk({tag, " done_seen"}, 64'(seenDone), 64'(1));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(33));
    chk({tag, " ready_while_stalled"}, 64'(earlyReady), 64'(0));
    chk({tag, " ready"}, 64'(div_readyE), 64'(1));
    chk({tag, " result"}, div_resultE, {expR, expQ});
    $display("[TB] %s: %h / %h -> q=%h r=%h after %0d stall cycles", tag, a, b,
             div_resultE[QUO_LSB +: W], div_resultE[REM_LSB +: W], stalls);
    nextCycle();
    startE = 1'b0;
  endtask

  initial begin
    int readySeen;
    rst     = 1'b1;
    startE  = 1'b0;
    signedE = 1'b0;
    opaE    = '0;
    opbE    = '0;
    cancelE = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    chk("reset stall", 64'(divstallE), 64'(0));
    chk("reset ready", 64'(div_readyE), 64'(0));
    chk("reset result", div_resultE, 64'(0));
    $display("[TB] reset: stall=%b ready=%b result=%h", divstallE, div_readyE, div_resultE);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    runDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7");
    @(negedge clk);
    chk("idle stall", 64'(divstallE), 64'(0));
    chk("idle ready", 64'(div_readyE), 64'(0));
    chk("idle result held", div_resultE, {32'd2, 32'd14});
    $display("[TB] idle after DONE: stall=%b ready=%b result=%h", divstallE, div_readyE, div_resultE);
    nextCycle();

    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2");
    runDiv(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, "divu 0xfffffff9/2");
    runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div 7/-2");
    runDiv(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "div by zero");
    runDiv(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "divu by zero");
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div overflow");

    // Cancel in BUSY iteration 10.
    startE  = 1'b1;
    signedE = 1'b0;
    opaE    = 32'd1000;
    opbE    = 32'd3;
    @(negedge clk);
    chk("cancel accept stall", 64'(divstallE), 64'(1));
    repeat (11) nextCycle();
    cancelE = 1'b1;
    @(negedge clk);
    chk("cancel stall drop", 64'(divstallE), 64'(0));
    nextCycle();
    cancelE = 1'b0;
    startE  = 1'b0;
    readySeen = 0;
    @(negedge clk);
    chk("cancel idle stall", 64'(divstallE), 64'(0));
    if (div_readyE) readySeen++;
    nextCycle();
    @(negedge clk);
    if (div_readyE) readySeen++;
    chk("cancel no ready", 64'(readySeen), 64'(0));
    $display("[TB] cancel at iteration 10: stall dropped, ready seen %0d times", readySeen);
    nextCycle();
    runDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu 100/7 after cancel");

    // Back-to-back pair, then a third divide interrupted by reset.
    runDiv(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, "divu 20/3");
    runDiv(1'b0, 32'd9, 32'd9, 32'd1, 32'd0, "divu 9/9");
    startE = 1'b1;
    opaE   = 32'd50;
    opbE   = 32'd5;
    repeat (10) nextCycle();
    rst    = 1'b1;
    startE = 1'b0;
    nextCycle();
    @(negedge clk);
    chk("mid reset stall", 64'(divstallE), 64'(0));
    chk("mid reset ready", 64'(div_readyE), 64'(0));
    chk("mid reset result", div_resultE, 64'(0));
    nextCycle();
    rst = 1'b0;
    readySeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_readyE || divstallE) readySeen++;
      nextCycle();
    end
    chk("post reset quiet", 64'(readySeen), 64'(0));
    $display("[TB] reset mid-divide: outputs cleared, %0d active cycles afterwards", readySeen);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no completion, expected completion before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
